// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci/BCD engine.
// Also provides the digit-count helper used to validate D against W.
package fib_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_OP,
      S_CONV,
      S_DONE
   } state_t;

   localparam logic [3:0] BCD_ADJ_TH  = 4'd5;
   localparam logic [3:0] BCD_ADJ_ADD = 4'd3;

   // Decimal digits needed to show the largest W-bit value.
   function automatic int min_bcd_digits(input int w);
      longint v;
      int     d;
      v = (longint'(1) << w) - 1;
      d = 1;
      while (v >= 10) begin
         v = v / 10;
         d = d + 1;
      end
      return d;
   endfunction

endpackage

// File: rtl/fib_bcd_conv.sv
// Sequential double-dabble: binary to packed BCD in exactly W cycles.
// Load on i_start; o_done is high in the final iteration cycle.
module fib_bcd_conv
   import fib_pkg::*;
#(
   parameter int W = 16,
   parameter int D = 5
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           i_start,
   input  logic [W-1:0]   i_bin,
   output logic           o_done,
   output logic [4*D-1:0] o_bcd
);

   localparam int SW = 4*D + W;
   localparam int CW = $clog2(W + 1);

   logic [SW-1:0] r_sr;
   logic [CW-1:0] r_cnt;
   logic          r_busy;
   logic [SW-1:0] w_adj;
   logic [SW-1:0] w_sr_nxt;

   assign w_adj[W-1:0] = r_sr[W-1:0];

   for (genvar g = 0; g < D; g++) begin : g_dig
      logic [3:0] w_nib;
      assign w_nib = r_sr[W+4*g +: 4];
      assign w_adj[W+4*g +: 4] =
         (w_nib >= BCD_ADJ_TH) ? w_nib + BCD_ADJ_ADD : w_nib;
   end

   assign w_sr_nxt = w_adj << 1;
   assign o_done   = r_busy && (r_cnt == CW'(W - 1));
   // Final digits are exposed the cycle they are formed.
   assign o_bcd    = w_sr_nxt[SW-1:W];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sr   <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_start) begin
         r_sr   <= {{(4*D){1'b0}}, i_bin};
         r_cnt  <= '0;
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_sr  <= w_sr_nxt;
         r_cnt <= r_cnt + CW'(1);
         if (o_done)
            r_busy <= 1'b0;
      end
   end

endmodule

// File: rtl/fib_bcd_core.sv
// Iterative saturating Fibonacci engine with BCD result.
// Latency is max(1,i)+W+1 cycles from the accepted start.
module fib_bcd_core
   import fib_pkg::*;
#(
   parameter int IW = 5,
   parameter int W  = 16,
   parameter int D  = 5
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [IW-1:0]  i,
   output logic           ready,
   output logic           done_tick,
   output logic           overflow,
   output logic [W-1:0]   f,
   output logic [4*D-1:0] bcd
);

   if (D < min_bcd_digits(W)) begin : g_chk
      $fatal(1, "fib_bcd_core: D too small for W");
   end

   state_t         r_state;
   state_t         w_state_nxt;
   logic [IW-1:0]  r_n;
   logic [W-1:0]   r_t0;
   logic [W-1:0]   r_t1;
   logic           r_ovf;
   logic [W-1:0]   r_f;
   logic [4*D-1:0] r_bcd;
   logic           r_overflow;
   logic [W:0]     w_sum;
   logic           w_last;
   logic           w_conv_start;
   logic [W-1:0]   w_conv_bin;
   logic           w_conv_done;
   logic [4*D-1:0] w_conv_bcd;

   assign w_sum        = {1'b0, r_t0} + {1'b0, r_t1};
   assign w_last       = (r_n < IW'(2));
   assign w_conv_start = (r_state == S_OP) && w_last;
   // fib(0) clears t1 on the same edge the converter loads.
   assign w_conv_bin   = (r_n == '0) ? '0 : r_t1;

   assign ready     = (r_state == S_IDLE);
   assign done_tick = (r_state == S_DONE);
   assign overflow  = r_overflow;
   assign f         = r_f;
   assign bcd       = r_bcd;

   fib_bcd_conv #(.W(W), .D(D)) u_conv (
      .clk     (clk),
      .reset   (reset),
      .i_start (w_conv_start),
      .i_bin   (w_conv_bin),
      .o_done  (w_conv_done),
      .o_bcd   (w_conv_bcd)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: if (start) w_state_nxt = S_OP;
         S_OP:   if (w_last) w_state_nxt = S_CONV;
         S_CONV: if (w_conv_done) w_state_nxt = S_DONE;
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_n        <= '0;
         r_t0       <= '0;
         r_t1       <= '0;
         r_ovf      <= 1'b0;
         r_f        <= '0;
         r_bcd      <= '0;
         r_overflow <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_n   <= i;
                  r_t0  <= '0;
                  r_t1  <= W'(1);
                  r_ovf <= 1'b0;
               end
            end
            S_OP: begin
               if (r_n == '0) begin
                  r_t1 <= '0;
               end else if (!w_last) begin
                  r_t0 <= r_t1;
                  r_n  <= r_n - IW'(1);
                  if (w_sum[W] || r_ovf) begin
                     r_ovf <= 1'b1;
                     r_t1  <= '1;
                  end else begin
                     r_t1 <= w_sum[W-1:0];
                  end
               end
            end
            S_CONV: begin
               // Results are valid throughout the done_tick cycle.
               if (w_conv_done) begin
                  r_f        <= r_t1;
                  r_bcd      <= w_conv_bcd;
                  r_overflow <= r_ovf;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/fib_bcd_core.md
Name: fib_bcd_core

Overview:
- Parametrised successor to the chapter-6 Fibonacci engine.
- Computes fib(i) iteratively at configurable index and result widths.
- Detects overflow and saturates the result.
- Converts the result to packed BCD with a sequential double-dabble, so display logic can consume decimal digits directly.
- Sits between the debounced switch/button front end and the hex display mux of the test top.

Parameters:
- IW, 5, index width; i ranges 0..2^IW-1
- W, 16, result width in bits
- D, 5, number of BCD output digits; must satisfy 10^D > 2^W-1 (elaboration-time check, fatal if violated)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  single-cycle request tick, honoured only when ready=1
- i  input  IW  Fibonacci index, sampled on the accepted start cycle only
- ready  output  1  high in IDLE only (combinational from state)
- done_tick  output  1  one-cycle pulse when f/bcd/overflow become valid
- overflow  output  1  registered; set when fib(i) > 2^W-1
- f  output  W  registered binary result, saturated to 2^W-1 on overflow
- bcd  output  4*D  registered packed BCD of f, digit 0 in bits [3:0]

Behaviour:
- Reset: state=IDLE, ready=1, done_tick=0, overflow=0, f=0, bcd=0, all internal registers 0. A reset asserted mid-operation aborts immediately; no done_tick is issued.
- States: IDLE, OP, CONV, DONE.
- IDLE: on start=1, latch n<=i, t0<=0, t1<=1, ovf<=0, then go to OP. start outside IDLE is ignored (no queueing).
- OP, one cycle per step:
  - n==0: t1<=0, go to CONV.
  - n==1: go to CONV.
  - otherwise: t0<=t1, t1<=t0+t1 computed at W+1 bits, n<=n-1.
  - If the carry bit is set or ovf is already set: ovf<=1 and t1 holds 2^W-1 (saturate; later additions are not used).
- CONV: shift register sr of 4*D+W bits loaded with {0, t1} on entry. Runs exactly W iterations; each iteration adds 3 to every BCD nibble >=5, then shifts sr left by 1. A W-bit-range counter tracks iterations.
- DONE: f<=t1, bcd<=sr BCD field, overflow<=ovf. done_tick=1 for this single cycle, then return to IDLE.
- Latency: with start accepted at cycle 0, OP occupies cycles 1..max(1,i), CONV the next W cycles, and done_tick is high in cycle max(1,i)+W+1.
- Outputs hold their last values until the next DONE. They are not cleared on a new start.
- i=0 and i=1 both take one OP cycle. A maximum index with saturation still runs the full i OP cycles (deterministic latency).

Decomposition:
- Shared package (fib_pkg):
  - state encoding constants (IDLE, OP, CONV, DONE)
  - localparam for the BCD adjust threshold (5) and add value (3)
  - helper function computing the minimum D for a given W, used by the elaboration check
- Sub-module fib_bcd_conv: sequential double-dabble with start/done handshake and W-cycle fixed latency. The core instantiates it and waits on its done. Its internal nibble adjust is a generate loop over D digits.

Test Plan (defaults IW=5, W=16, D=5; start pulsed in cycle 0):
- Reset, then i=0 -> done_tick at cycle 18, f=0, bcd=0x00000, overflow=0; ready low in cycles 1..17, high at 19.
- i=10 -> done_tick at cycle 27, f=55, bcd=0x00055, overflow=0.
- i=24 -> f=46368 (0xB520), bcd=0x46368, overflow=0; i=1 back-to-back after ready -> f=1, bcd=0x00001.
- i=25 and i=31 -> overflow=1, f=0xFFFF, bcd=0x65535; done_tick for i=31 at cycle 48.
- start re-pulsed with i=3 while busy on i=10 -> ignored, result still 55. Reset asserted during OP -> outputs return to 0, ready=1, no done_tick.
